// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the shared memory port.
// The arbiter connects through the master view; the pipeline and RAM through the slave view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;
  logic              bus_err;

  modport master (
    input  if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata,
    input  ram_rdata, ram_ack,
    output if_rdata, mem_rdata, stall,
    output ram_req, ram_we, ram_addr, ram_wdata, bus_err
  );

  modport slave (
    output if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata,
    output ram_rdata, ram_ack,
    input  if_rdata, mem_rdata, stall,
    input  ram_req, ram_we, ram_addr, ram_wdata, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency single-port memory between instruction fetch and
// load/store; data accesses go first and the pipeline stalls until the step completes.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input logic                clock,
  input logic                reset,
  mem_port_arbiter_if.master bus
);

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    INSTR
  } state_t;

  state_t              state;
  logic                d_served;
  logic                i_served;
  logic                d_pend;
  logic                i_pend;
  logic                stall;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                timeout;

  logic                ram_req;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   if_rdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                bus_err;

  assign d_pend  = (bus.mem_read | bus.mem_write) & ~d_served;
  assign i_pend  = bus.if_req & ~i_served;
  assign stall   = d_pend | i_pend;
  assign timeout = (wait_cnt == WAIT_W'(MAX_WAIT));

  assign bus.stall     = stall;
  assign bus.ram_req   = ram_req;
  assign bus.ram_we    = ram_we;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_wdata = ram_wdata;
  assign bus.if_rdata  = if_rdata;
  assign bus.mem_rdata = mem_rdata;
  assign bus.bus_err   = bus_err;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      d_served  <= 1'b0;
      i_served  <= 1'b0;
      wait_cnt  <= '0;
      bus_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (d_pend) begin
            state     <= DATA;
            ram_req   <= 1'b1;
            ram_we    <= bus.mem_write;
            ram_addr  <= bus.mem_addr;
            ram_wdata <= bus.mem_wdata;
          end else if (i_pend) begin
            state    <= INSTR;
            ram_req  <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= bus.if_addr;
          end else begin
            ram_req <= 1'b0;
          end
        end
        DATA, INSTR: begin
          if (bus.ram_ack) begin
            state   <= IDLE;
            ram_req <= 1'b0;
            ram_we  <= 1'b0;
            if (state == DATA) begin
              d_served <= 1'b1;
              if (!ram_we) mem_rdata <= bus.ram_rdata;
            end else begin
              i_served <= 1'b1;
              if_rdata <= bus.ram_rdata;
            end
          end else if (timeout) begin
            state   <= IDLE;
            ram_req <= 1'b0;
            ram_we  <= 1'b0;
            bus_err <= 1'b1;
            if (state == DATA) begin
              d_served  <= 1'b1;
              mem_rdata <= '1;
            end else begin
              i_served <= 1'b1;
              if_rdata <= '1;
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          ram_req <= 1'b0;
          ram_we  <= 1'b0;
        end
      endcase

      // Placed after the case so a step ending on this edge also discards a
      // served flag being set by a transfer whose request already dropped.
      if (!stall) begin
        d_served <= 1'b0;
        i_served <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by randomized steps; a RAM responder model serves
// requests and a monitor checks transactions and step results against queued expectations.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic [31:0] mrd;
    logic [31:0] ird;
    logic        berr;
    int          cycles;
  } step_t;

  int checks = 0;
  int errors = 0;

  txn_t  exp_txn[$];
  step_t exp_step[$];
  int    lat_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] resp_mem[logic [31:0]];

  bit auto_on = 1'b0;
  int steps_done = 0;

  logic        man_ack, rsp_ack;
  logic [31:0] man_rdata, rsp_rdata;
  assign bus.ram_ack   = auto_on ? rsp_ack : man_ack;
  assign bus.ram_rdata = auto_on ? rsp_rdata : man_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic report();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  // RAM responder: latency per transaction from lat_q, negative means never ack.
  initial begin
    int lat;
    rsp_ack   = 1'b0;
    rsp_rdata = '0;
    forever begin
      @(negedge clock);
      if (auto_on && reset && bus.ram_req) begin
        check("resp_lat_available", 32'(lat_q.size() != 0), 32'd1);
        lat = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
        if (lat < 0) begin
          for (int k = 0; k < MW + 4 && bus.ram_req; k++) @(negedge clock);
        end else begin
          repeat (lat) @(negedge clock);
          rsp_ack = 1'b1;
          if (bus.ram_we) begin
            resp_mem[bus.ram_addr] = bus.ram_wdata;
            rsp_rdata = $urandom;
          end else begin
            rsp_rdata = resp_mem.exists(bus.ram_addr) ? resp_mem[bus.ram_addr]
                                                      : init_word(bus.ram_addr);
          end
          @(negedge clock);
          rsp_ack   = 1'b0;
          rsp_rdata = $urandom;
        end
      end
    end
  end

  // Monitor: checks each issued transaction and each completed step.
  initial begin
    logic prev_req, prev_stall;
    int   stall_cyc;
    txn_t t;
    step_t s;
    prev_req = 1'b0;
    prev_stall = 1'b0;
    stall_cyc = 0;
    forever begin
      @(negedge clock);
      if (auto_on) begin
        if (bus.ram_req && !prev_req) begin
          check("txn_expected", 32'(exp_txn.size() != 0), 32'd1);
          if (exp_txn.size() != 0) begin
            t = exp_txn.pop_front();
            check("txn_we", 32'(bus.ram_we), 32'(t.we));
            check("txn_addr", bus.ram_addr, t.addr);
            if (t.we) check("txn_wdata", bus.ram_wdata, t.wdata);
          end
        end
        if (bus.stall) begin
          stall_cyc++;
        end else if (prev_stall) begin
          check("step_expected", 32'(exp_step.size() != 0), 32'd1);
          if (exp_step.size() != 0) begin
            s = exp_step.pop_front();
            check("step_mem_rdata", bus.mem_rdata, s.mrd);
            check("step_if_rdata", bus.if_rdata, s.ird);
            check("step_bus_err", 32'(bus.bus_err), 32'(s.berr));
            check("step_stall_cycles", 32'(stall_cyc), 32'(s.cycles));
          end
          stall_cyc = 0;
          steps_done++;
        end
      end
      prev_req   = bus.ram_req;
      prev_stall = bus.stall;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    report();
    $finish;
  end

  initial begin
    int req_cyc;
    logic [31:0] model_mrd, model_ird;
    logic model_berr;
    bit stuck;

    man_ack = 1'b0;
    man_rdata = '0;
    reset = 1'b0;
    idle_inputs();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h40;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;

    // Reset held two cycles with a fetch request present
    tick();
    tick();
    check("rst_ram_req", 32'(bus.ram_req), 32'd0);
    check("rst_ram_we", 32'(bus.ram_we), 32'd0);
    check("rst_ram_addr", bus.ram_addr, 32'd0);
    check("rst_ram_wdata", bus.ram_wdata, 32'd0);
    check("rst_if_rdata", bus.if_rdata, 32'd0);
    check("rst_mem_rdata", bus.mem_rdata, 32'd0);
    check("rst_bus_err", 32'(bus.bus_err), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd1);

    // Fetch: stall 4 cycles, ack in 3rd cycle of ram_req
    reset = 1'b1;
    tick();
    check("fetch_ram_req", 32'(bus.ram_req), 32'd1);
    check("fetch_ram_addr", bus.ram_addr, 32'h40);
    check("fetch_ram_we", 32'(bus.ram_we), 32'd0);
    tick();
    check("fetch_stall_mid", 32'(bus.stall), 32'd1);
    tick();
    man_ack = 1'b1;
    man_rdata = 32'h8C02_0004;
    tick();
    man_ack = 1'b0;
    check("fetch_stall_end", 32'(bus.stall), 32'd0);
    check("fetch_if_rdata", bus.if_rdata, 32'h8C02_0004);
    check("fetch_ram_req_end", 32'(bus.ram_req), 32'd0);
    idle_inputs();
    tick();

    // Simultaneous: data first, then fetch
    bus.if_req = 1'b1;
    bus.if_addr = 32'h44;
    bus.mem_read = 1'b1;
    bus.mem_addr = 32'h100;
    tick();
    check("sim_first_addr", bus.ram_addr, 32'h100);
    check("sim_first_req", 32'(bus.ram_req), 32'd1);
    man_ack = 1'b1;
    man_rdata = 32'h11;
    tick();
    man_ack = 1'b0;
    check("sim_gap_req", 32'(bus.ram_req), 32'd0);
    check("sim_gap_stall", 32'(bus.stall), 32'd1);
    check("sim_mem_rdata", bus.mem_rdata, 32'h11);
    check("sim_if_hold", bus.if_rdata, 32'h8C02_0004);
    tick();
    check("sim_second_req", 32'(bus.ram_req), 32'd1);
    check("sim_second_addr", bus.ram_addr, 32'h44);
    man_ack = 1'b1;
    man_rdata = 32'h22;
    tick();
    man_ack = 1'b0;
    check("sim_stall_end", 32'(bus.stall), 32'd0);
    check("sim_if_rdata", bus.if_rdata, 32'h22);
    check("sim_mem_rdata_end", bus.mem_rdata, 32'h11);
    idle_inputs();
    tick();

    // Store
    bus.mem_write = 1'b1;
    bus.mem_addr = 32'h200;
    bus.mem_wdata = 32'hDEAD;
    tick();
    check("store_we", 32'(bus.ram_we), 32'd1);
    check("store_addr", bus.ram_addr, 32'h200);
    check("store_wdata", bus.ram_wdata, 32'hDEAD);
    man_ack = 1'b1;
    man_rdata = 32'h5555;
    tick();
    man_ack = 1'b0;
    check("store_stall_end", 32'(bus.stall), 32'd0);
    check("store_mem_rdata", bus.mem_rdata, 32'h11);
    idle_inputs();
    tick();

    // Timeout with no ack
    bus.mem_read = 1'b1;
    bus.mem_addr = 32'h300;
    req_cyc = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.ram_req) req_cyc++;
      else if (req_cyc > 0) break;
    end
    check("to_req_cycles", 32'(req_cyc), 32'(MW + 1));
    check("to_bus_err", 32'(bus.bus_err), 32'd1);
    check("to_mem_rdata", bus.mem_rdata, 32'hFFFF_FFFF);
    check("to_stall", 32'(bus.stall), 32'd0);
    idle_inputs();
    tick();
    tick();
    check("to_bus_err_sticky", 32'(bus.bus_err), 32'd1);

    // Reset in second DATA cycle, late ack afterwards
    bus.mem_read = 1'b1;
    bus.mem_addr = 32'h400;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    idle_inputs();
    man_ack = 1'b1;
    man_rdata = 32'h99;
    check("rmid_ram_req", 32'(bus.ram_req), 32'd0);
    check("rmid_bus_err", 32'(bus.bus_err), 32'd0);
    tick();
    man_ack = 1'b0;
    check("rmid_ram_req_after", 32'(bus.ram_req), 32'd0);
    check("rmid_mem_rdata", bus.mem_rdata, 32'd0);
    check("rmid_stall", 32'(bus.stall), 32'd0);
    tick();

    // Randomized steps
    model_mrd = '0;
    model_ird = '0;
    model_berr = 1'b0;
    stuck = 1'b0;
    auto_on = 1'b1;
    tick();
    for (int s = 0; s < 150 && !stuck; s++) begin
      int kind, lat, target;
      logic do_d, do_w, do_f;
      logic [31:0] a_d, a_f, wd;
      step_t st;
      kind = int'($urandom_range(0, 4));
      do_f = (kind == 0) || (kind >= 3);
      do_d = (kind != 0);
      do_w = (kind == 2) || (kind == 4);
      a_d = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
      a_f = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
      wd = $urandom;
      st.cycles = 0;
      if (do_d) begin
        if (do_w || $urandom_range(0, 7) != 0) lat = int'($urandom_range(0, MW));
        else lat = -1;
        exp_txn.push_back('{we: do_w, addr: a_d, wdata: wd});
        lat_q.push_back(lat);
        st.cycles += ((lat < 0) ? MW : lat) + 2;
        if (do_w) begin
          ref_mem[a_d] = wd;
        end else if (lat < 0) begin
          model_mrd = '1;
          model_berr = 1'b1;
        end else begin
          model_mrd = ref_read(a_d);
        end
      end
      if (do_f) begin
        lat = ($urandom_range(0, 7) != 0) ? int'($urandom_range(0, MW)) : -1;
        exp_txn.push_back('{we: 1'b0, addr: a_f, wdata: 32'd0});
        lat_q.push_back(lat);
        st.cycles += ((lat < 0) ? MW : lat) + 2;
        if (lat < 0) begin
          model_ird = '1;
          model_berr = 1'b1;
        end else begin
          model_ird = ref_read(a_f);
        end
      end
      st.mrd = model_mrd;
      st.ird = model_ird;
      st.berr = model_berr;
      exp_step.push_back(st);

      bus.if_req = do_f;
      bus.if_addr = a_f;
      bus.mem_write = do_w;
      bus.mem_read = (do_d && !do_w) || (do_w && $urandom_range(0, 3) == 0);
      bus.mem_addr = a_d;
      bus.mem_wdata = wd;

      target = steps_done + 1;
      for (int k = 0; k < 60 && steps_done < target; k++) @(posedge clock);
      if (steps_done < target) begin
        check("step_completed", 32'd0, 32'd1);
        stuck = 1'b1;
      end
      #1;
      if ($urandom_range(0, 2) == 0) begin
        idle_inputs();
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    idle_inputs();
    repeat (4) tick();
    check("end_txn_queue", 32'(exp_txn.size()), 32'd0);
    check("end_step_queue", 32'(exp_step.size()), 32'd0);
    check("end_lat_queue", 32'(lat_q.size()), 32'd0);
    report();
    $finish;
  end

endmodule
